// File: rtl/debugger_tx.sv
// debugger_tx: transmit half of the debug UART link.
// On a sendSignal request the pipeline-state word is snapshotted and streamed
// LSB-first, one byte per tx_start/tx_done_tick handshake, into the UART TX
// core. Completion is acknowledged with a level dataSent that stays high until
// the requester drops sendSignal (four-phase handshake).
module debugger_tx #(
  parameter int NUM_BYTES = 220,
  parameter int CNT_W     = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sendSignal,
  input  logic [8*NUM_BYTES-1:0] sendData,
  input  logic                   tx_done_tick,
  output logic                   tx_start,
  output logic [7:0]             w_data,
  output logic                   dataSent,
  output logic                   busy
);

  localparam int              DW       = 8 * NUM_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    snap_q, snap_d;
  logic [DW-1:0]    snap_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       w_data_q, w_data_d;
  logic             sent_q, sent_d;
  logic             busy_q, busy_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would infer a latch.
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    w_data_d   = w_data_q;
    snap_shift = snap_q >> 8;

    case (state_q)
      S_IDLE: begin
        if (sendSignal) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Capture the snapshot; the first byte comes straight from sendData so
        // it is on w_data in the same cycle tx_start pulses.
        snap_d   = sendData;
        cnt_d    = '0;
        w_data_d = sendData[7:0];
        state_d  = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            snap_d   = snap_shift;
            cnt_d    = cnt_q + CNT_W'(1);
            w_data_d = snap_shift[7:0];
            state_d  = S_SEND;
          end
        end
      end
      S_DONE: begin
        // Hold the acknowledge until the request is withdrawn, so a request
        // that is still high cannot start a second dump.
        if (!sendSignal) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are valid with it.
    if (state_d == S_IDLE) w_data_d = 8'h00;
    tx_start_d = (state_d == S_SEND);
    sent_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      // NOTE: the wide snapshot is reset too, so no stale pipeline state from
      // before the reset can ever be observed on w_data.
      snap_q     <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      w_data_q   <= 8'h00;
      sent_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      w_data_q   <= w_data_d;
      sent_q     <= sent_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_start = tx_start_q;
  assign w_data   = w_data_q;
  assign dataSent = sent_q;
  assign busy     = busy_q;

endmodule

// File: doc/debugger_tx.md
Name: debugger_tx

Overview:
- Transmit half of the debug UART link.
- When the command receiver raises sendSignal, this block snapshots a wide pipeline-state word. It then streams that word byte by byte into the UART transmitter using a start/done handshake.
- It answers the receiver with dataSent using a four-phase level handshake.
- It sits between the debug command FSM, the pipeline state collector and the UART TX core.

Parameters:
- NUM_BYTES, 220: number of bytes in one snapshot; sendData width = 8*NUM_BYTES (default 1760 bits). Legal range 1..1023.
- CNT_W, 10: byte counter width; must satisfy 2^CNT_W > NUM_BYTES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sendSignal  input  1  level request from the command receiver; high = dump snapshot.
- sendData  input  8*NUM_BYTES  pipeline state; sampled only in LOAD.
- tx_done_tick  input  1  one-cycle pulse from the UART TX core when the current byte has finished shifting out.
- tx_start  output  1  one-cycle pulse telling the UART TX core to send w_data.
- w_data  output  8  byte presented to the UART TX core; stable from tx_start until tx_done_tick.
- dataSent  output  1  level acknowledge; high while in DONE.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs and state are registered. Asynchronous reset forces:
  - state=IDLE, tx_start=0, w_data=8'h00, dataSent=0, busy=0;
  - byte counter=0, snapshot register=0.
- Reset mid-transfer aborts immediately. No further tx_start is issued. On release the block sits in IDLE until it sees sendSignal high.
- States: IDLE, LOAD, SEND, WAIT, DONE.
- IDLE:
  - If sendSignal=1, go to LOAD next cycle.
  - Otherwise stay in IDLE with all outputs at reset values.
- LOAD (1 cycle):
  - snapshot <= sendData; counter <= 0; busy=1; go to SEND.
  - Later changes on sendData do not affect the transfer in progress.
- SEND (1 cycle):
  - w_data <= snapshot[7:0]; tx_start pulses high for exactly this one cycle; go to WAIT.
- WAIT:
  - tx_start=0; w_data held.
  - On tx_done_tick=1:
    - if counter==NUM_BYTES-1, go to DONE;
    - else snapshot shifts right by 8, counter increments, go to SEND.
  - A tx_done_tick arriving in any state other than WAIT is ignored.
- Byte order: least-significant byte first, so sendData[7:0] is the first byte on the wire and sendData[8*NUM_BYTES-1 -: 8] is the last.
- Exactly NUM_BYTES tx_start pulses are issued per transfer.
- Latency: sendSignal rising edge to first tx_start is 2 cycles (IDLE->LOAD->SEND). Last tx_done_tick to dataSent high is 1 cycle.
- DONE:
  - dataSent=1, busy=1.
  - Stay in DONE while sendSignal=1.
  - When sendSignal=0, go to IDLE; dataSent drops on that transition.
  - This prevents a still-high sendSignal from retriggering a second dump.
- sendSignal dropping before DONE is ignored. The transfer always completes, and then DONE exits on the first cycle it sees sendSignal=0.
- Counter never wraps: its terminal value is NUM_BYTES-1 and it is cleared only in LOAD or by reset.
- NUM_BYTES=1: SEND, WAIT, then DONE after a single tx_done_tick.

Test Plan:
- Reset, NUM_BYTES=4, sendData=32'hDDCCBBAA. Raise sendSignal and answer each tx_start with tx_done_tick 5 cycles later.
  -> w_data sequence AA, BB, CC, DD; exactly 4 tx_start pulses, each 1 cycle wide; first tx_start 2 cycles after sendSignal; dataSent high 1 cycle after the 4th done tick.
- After dataSent, hold sendSignal high 10 more cycles, then drop it.
  -> dataSent stays 1 throughout with no new tx_start; dataSent=0 and busy=0 the cycle after sendSignal falls; nothing is transmitted again.
- Change sendData to 32'h11223344 one cycle after LOAD.
  -> transmitted bytes are still AA, BB, CC, DD.
- Assert reset asynchronously while in WAIT after byte 2.
  -> tx_start, dataSent, busy and w_data are 0 immediately; no further tx_start. A later sendSignal restarts from byte AA.
- Inject tx_done_tick while in IDLE and in SEND.
  -> no state change and no counter advance; the transfer still emits 4 bytes.
- NUM_BYTES=220, sendData byte i = i[7:0].
  -> 220 bytes 00..DB in order; dataSent asserted once.
